multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle RV32I core. Sequences the shared datapath (PC, instruction register, ALU, register file, unified memory port) through fetch, decode and per-class execute/writeback states. Drives every datapath select and write-enable, including the `ImmSrc` code consumed by the immediate extender. Next to the datapath top; no other sequencing logic exists in the core.

## Interface
- `ImmSrc` encoding: 000 I-sext, 001 S, 010 B, 100 J, 101 U; 110 (I-zext) is reserved and never driven by this block.
- `clk`  in  1  core clock
- `rst`  in  1  reset; synchronous, active-high
- `op`  in  7  instr[6:0] from instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `Zero`  in  1  ALU zero flag, same cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address: 0 PC, 1 Result
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction/OldPC register enable
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 RD1
- `ALUSrcB`  out  2  00 RD2, 01 ImmExt, 10 constant 4
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `ImmSrc`  out  3  immediate format, as above
- `RegWrite`  out  1  register file write enable
- `InstrDone`  out  1  one-cycle pulse on the last state of each instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI.
- FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: SrcA=01, SrcB=01, ALUOp=add (branch target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - any other op → FETCH, InstrDone=1 (illegal op is treated as NOP)
- MEMADR: SrcA=10, SrcB=01, add. Next is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Next is FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, InstrDone=1. Next is FETCH.
- EXECR: SrcA=10, SrcB=00, ALUOp=funct. Next is ALUWB.
- EXECI: SrcA=10, SrcB=01, ALUOp=funct. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Next is FETCH.
- BRANCH: SrcA=10, SrcB=00, ALUOp=sub, ResultSrc=00.
  - PCWrite = Zero XOR funct3[0], so beq (000) and bne (001) are both supported.
  - InstrDone=1. Next is FETCH.
- JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1. Next is ALUWB (writes PC+4).
- LUI: ResultSrc=11, RegWrite=1, InstrDone=1. Next is FETCH.
- Any output not listed for a state is 0 in that state.
- ALU decode, ALUOp=funct:
  - funct3 000 → sub if (op[5] & funct7b5), else add
  - 010 → slt; 110 → or; 111 → and
  - any other funct3 → add
- `ImmSrc` is purely combinational from `op`, independent of state:
  - 0100011 → 001; 1100011 → 010; 1101111 → 100; 0110111 → 101
  - all other op → 000

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational from the state plus `op`/`funct3`/`funct7b5`/`Zero`.
- While `rst`=1: state is held at FETCH, and PCWrite, IRWrite, MemWrite, RegWrite and InstrDone are forced to 0. Select outputs take their FETCH values.
- The first cycle after `rst` falls is a FETCH with enables active.
- `rst` asserted mid-instruction: the next edge returns the FSM to FETCH. No write enable is asserted in that cycle; the partial instruction is abandoned.
- Cycle counts, FETCH to InstrDone inclusive:
  - lw 5; sw 4; R/I-type 4; beq/bne 3; jal 4; lui 3; illegal 2.
- `Zero` is sampled only in BRANCH, in the same cycle.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the state enum
  - `ImmSrc`, `ALUControl`, `ResultSrc` and `ALUSrc*` encodings as localparams
  - opcode constants
- One sub-module `alu_decoder` (ALUOp, funct3, op[5], funct7b5 → ALUControl), instantiated once.

## Test plan
- `rst`=1 for 3 cycles, release, then lw (op 0000011): states run FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; ImmSrc=000 throughout.
- sw (0100011): MemWrite=1 and AdrSrc=1 in cycle 4 only; ImmSrc=001; InstrDone in cycle 4.
- R-type funct3=000, funct7b5=1: ALUControl=001 in EXECR; with funct7b5=1 on I-type (0010011), ALUControl=000.
- beq with Zero=1 → PCWrite=1 in cycle 3. bne (funct3=001) with Zero=1 → PCWrite=0. ImmSrc=010.
- jal: PCWrite in JAL, then ALUWB with RegWrite=1; ImmSrc=100. lui: ResultSrc=11, RegWrite=1 in cycle 3; ImmSrc=101. Op 1111111: DECODE→FETCH, InstrDone=1, no writes.
- Assert `rst` during MEMREAD of lw: no RegWrite ever asserted for that lw; FSM is in FETCH on the first cycle after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// datapath select codes, ALU operations and the opcodes the controller decodes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        LUI
    } state_t;

    // Operation class requested from the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_U    = 3'b101;
    localparam logic [2:0] IMM_IZ   = 3'b110;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU operation class plus instruction fields to ALUControl.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // sub only for R-type; addi with imm[10] set must stay add
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode and
// per-class execute/writeback, driving every datapath select and enable.
//
// state    | meaning
// FETCH    | read instruction at PC, latch IR/OldPC, PC <= PC+4
// DECODE   | read registers, ALUOut <= OldPC+imm (branch/jump target)
// MEMADR   | ALUOut <= rs1+imm (load/store address)
// MEMREAD  | read memory at ALUOut
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to memory at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, PC <= target when taken
// JAL      | PC <= target, ALUOut <= OldPC+4
// LUI      | write ImmExt to rd
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       InstrDone
);

    state_t state, state_next, out_state;
    aluop_t aluop;
    logic   pcwrite_raw, memwrite_raw, irwrite_raw, regwrite_raw, done_raw;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECR;
                    OP_ITYPE:          state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_LUI:            state_next = LUI;
                    default:           state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = MEMWB;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            JAL:      state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    // During reset the selects show FETCH values; enables are masked below
    assign out_state = rst ? FETCH : state;

    always_comb begin
        pcwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        done_raw     = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RD2;
        aluop        = ALUOP_ADD;
        case (out_state)
            FETCH: begin
                irwrite_raw = 1'b1;
                pcwrite_raw = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
                    OP_BRANCH, OP_JAL, OP_LUI: done_raw = 1'b0;
                    default:                   done_raw = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc    = RES_DATA;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc       = 1'b1;
                memwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                aluop   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = SRCA_RD1;
                aluop       = ALUOP_SUB;
                // funct3[0] inverts the sense: beq on Zero, bne on !Zero
                pcwrite_raw = Zero ^ funct3[0];
                done_raw    = 1'b1;
            end
            JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                pcwrite_raw = 1'b1;
            end
            LUI: begin
                ResultSrc    = RES_IMMEXT;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite   = pcwrite_raw  & ~rst;
    assign MemWrite  = memwrite_raw & ~rst;
    assign IRWrite   = irwrite_raw  & ~rst;
    assign RegWrite  = regwrite_raw & ~rst;
    assign InstrDone = done_raw     & ~rst;

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            OP_LUI:    ImmSrc = IMM_U;
            default:   ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected per-cycle output vectors
// are queued with each instruction and popped/compared one per clock.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    typedef struct {
        logic [17:0] vec;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .InstrDone  (InstrDone)
    );

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, InstrDone}
    task automatic push(input string tag, input logic pcw, input logic adr, input logic mw,
                        input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [2:0] alu, input logic [2:0] imm,
                        input logic rw, input logic done);
        exp_t e;
        e.vec = {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, done};
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t        e;
        logic [17:0] obs;
        @(negedge clk);
        obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, InstrDone};
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty observed=%b required=<queued entry>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.vec) else begin
                miscompares++;
                $error("FAIL %s observed=%b required=%b", e.tag, obs, e.vec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget = 20;
        while (q.size() > 0 && budget > 0) begin
            check_cycle();
            budget--;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_budget observed=%0d required=0 left in queue", q.size());
        end
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    endtask

    // FETCH and DECODE are common to every instruction
    task automatic push_fd(input string n, input logic [2:0] imm);
        push({n, ".fetch"},  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
        push({n, ".decode"}, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            push("reset", 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
        drain();
        rst = 1'b0;

        // lw
        push_fd("lw", 3'b000);
        push("lw.memadr",  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
        push("lw.memread", 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0);
        push("lw.memwb",   0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 1);
        drain();

        // sw
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
        push_fd("sw", 3'b001);
        push("sw.memadr",   0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0);
        push("sw.memwrite", 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 1);
        drain();

        // R-type sub
        set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
        push_fd("sub", 3'b000);
        push("sub.execr", 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0);
        push("sub.aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 1);
        drain();

        // addi with funct7b5=1 must stay add
        set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
        push_fd("addi", 3'b000);
        push("addi.execi", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
        push("addi.aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 1);
        drain();

        // or / slti / andi ALU decode
        set_in(7'b0110011, 3'b110, 1'b0, 1'b0);
        push_fd("or", 3'b000);
        push("or.execr", 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 3'b000, 0, 0);
        push("or.aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 1);
        drain();
        set_in(7'b0010011, 3'b010, 1'b0, 1'b0);
        push_fd("slti", 3'b000);
        push("slti.execi", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 3'b000, 0, 0);
        push("slti.aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 1);
        drain();
        set_in(7'b0010011, 3'b111, 1'b0, 1'b0);
        push_fd("andi", 3'b000);
        push("andi.execi", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0, 0);
        push("andi.aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 1);
        drain();

        // branches: PCWrite = Zero ^ funct3[0]
        set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
        push_fd("beq_z1", 3'b010);
        push("beq_z1.branch", 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 1);
        drain();
        set_in(7'b1100011, 3'b001, 1'b0, 1'b1);
        push_fd("bne_z1", 3'b010);
        push("bne_z1.branch", 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 1);
        drain();
        set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
        push_fd("beq_z0", 3'b010);
        push("beq_z0.branch", 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 1);
        drain();
        set_in(7'b1100011, 3'b001, 1'b0, 1'b0);
        push_fd("bne_z0", 3'b010);
        push("bne_z0.branch", 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 1);
        drain();

        // jal
        set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
        push_fd("jal", 3'b100);
        push("jal.jal",   1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b100, 0, 0);
        push("jal.aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100, 1, 1);
        drain();

        // lui
        set_in(7'b0110111, 3'b000, 1'b0, 1'b0);
        push_fd("lui", 3'b101);
        push("lui.lui", 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b000, 3'b101, 1, 1);
        drain();

        // illegal opcode: NOP, done in DECODE
        set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
        push("ill.fetch",  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
        push("ill.decode", 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 1);
        drain();

        // lw abandoned by reset in MEMREAD
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        push_fd("lwrst", 3'b000);
        push("lwrst.memadr", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
        drain();
        rst = 1'b1;
        push("lwrst.rst", 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
        drain();
        rst = 1'b0;
        push_fd("lwrst.after", 3'b000);
        push("lwrst.memadr2", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
